// File: rtl/convertidor_bcd_if.sv
// Handshake and result bus for convertidor_bcd.
// The caller (master) drives start/a; the converter (slave) drives busy/done/bcd/neg.
interface convertidor_bcd_if;
  logic        start;
  logic [13:0] a;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        neg;

  modport master (output start, output a, input busy, input done, input bcd, input neg);
  modport slave  (input start, input a, output busy, output done, output bcd, output neg);
endinterface

// File: rtl/convertidor_bcd.sv
// 14-bit binary to 5-digit packed BCD converter (double dabble, one bit per clock).
// Optional feature macro: CONVERTIDOR_SIGNED_EN treats the operand as two's
// complement and reports the sign on neg; undefined, neg is tied to 0.
module convertidor_bcd (
  input logic              clk,
  input logic              rst_n,
  convertidor_bcd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [33:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic [13:0] mag;
  logic [3:0]  nib;
  logic [19:0] adj;
  logic [33:0] pre_shift;
  logic [33:0] shifted;
`ifdef CONVERTIDOR_SIGNED_EN
  logic        neg_q, neg_d;
  logic        sign_q, sign_d;
  logic        mag_neg;
`endif

  // Operand magnitude: two's complement negation in 14 bits is exact even for -8192
`ifdef CONVERTIDOR_SIGNED_EN
  always_comb begin
    mag_neg = bus.a[13];
    mag     = mag_neg ? (~bus.a + 14'd1) : bus.a;
  end
`else
  always_comb begin
    mag = bus.a;
  end
`endif

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register
  always_comb begin
    nib = '0;
    adj = '0;
    for (int i = 0; i < 5; i++) begin
      nib = shreg_q[14 + 4*i +: 4];
      adj[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    pre_shift = {adj, shreg_q[13:0]};
    shifted   = pre_shift << 1;
  end

  // State register and datapath flops; reset discards any partial conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
`ifdef CONVERTIDOR_SIGNED_EN
      neg_q   <= 1'b0;
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
`ifdef CONVERTIDOR_SIGNED_EN
      neg_q   <= neg_d;
      sign_q  <= sign_d;
`endif
    end
  end

  // Next state and datapath updates; results land on the edge doing the 14th shift
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
`ifdef CONVERTIDOR_SIGNED_EN
    neg_d   = neg_q;
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          shreg_d = {20'b0, mag};
          cnt_d   = 4'd0;
`ifdef CONVERTIDOR_SIGNED_EN
          sign_d  = mag_neg;
`endif
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = DONE;
          bcd_d   = shifted[33:14];
`ifdef CONVERTIDOR_SIGNED_EN
          neg_d   = sign_q;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state and result flops only
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
    bus.bcd  = bcd_q;
`ifdef CONVERTIDOR_SIGNED_EN
    bus.neg  = neg_q;
`else
    bus.neg  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_convertidor_bcd.sv
// Self-checking bench for convertidor_bcd; results are checked by a scoreboard
// fed with decimal-arithmetic expectations. Honours CONVERTIDOR_SIGNED_EN.
module tb_convertidor_bcd;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [20:0] exp_q[$];

  convertidor_bcd_if bus_if ();

  convertidor_bcd dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {neg, bcd} built from ordinary integer division
  function automatic logic [20:0] model(input logic [13:0] v);
    int   m;
    logic n;
    n = 1'b0;
    m = int'(v);
`ifdef CONVERTIDOR_SIGNED_EN
    if (v[13]) begin
      n = 1'b1;
      m = 16384 - int'(v);
    end
`endif
    return {n, 4'(m / 10000), 4'((m / 1000) % 10), 4'((m / 100) % 10),
            4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Scoreboard: every done pulse pops the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus_if.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_done: got bcd=%05h neg=%0b, required no done", bus_if.bcd, bus_if.neg);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({bus_if.neg, bus_if.bcd} !== e) begin
          errors++;
          $display("[TB] FAIL sb_result: got neg=%0b bcd=%05h, required neg=%0b bcd=%05h",
                   bus_if.neg, bus_if.bcd, e[20], e[19:0]);
        end
      end
    end
  end

  // Drives one start pulse and checks the done latency of exactly 14 edges after accept
  task automatic convert(input logic [13:0] v);
    int done_at;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = v;
    exp_q.push_back(model(v));
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.a     = $urandom_range(0, 16383);
    done_at = -1;
    for (int i = 1; i < 20 && done_at < 0; i++) begin
      @(negedge clk);
      if (bus_if.done) done_at = i;
    end
    checks++;
    if (done_at != 14) begin
      errors++;
      $display("[TB] FAIL latency a=%0d: done seen at E+%0d, required E+14", v, done_at);
      if (done_at < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.neg, bus_if.bcd} !== 23'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%0b done=%0b neg=%0b bcd=%05h, required all 0",
               bus_if.busy, bus_if.done, bus_if.neg, bus_if.bcd);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int busy_cnt;
    int done_cnt;
    int done_at;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 14'd0;
    exp_q.push_back(model(14'd0));
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) begin
        done_cnt++;
        done_at = i;
      end
    end
    checks++;
    if (busy_cnt != 15) begin
      errors++;
      $display("[TB] FAIL zero_busy_cycles: got %0d, required 15", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != 14) begin
      errors++;
      $display("[TB] FAIL zero_done_pulse: got %0d pulses at E+%0d, required 1 at E+14", done_cnt, done_at);
    end
  endtask

  task automatic test_values();
`ifdef CONVERTIDOR_SIGNED_EN
    convert(14'h3FFF);
    convert(14'h2000);
    convert(14'h1FFF);
`else
    convert(14'h3FFF);
    convert(14'd9999);
`endif
    convert(14'd1);
    for (int i = 0; i < 6; i++) convert(14'($urandom_range(0, 16383)));
  endtask

  task automatic test_ignore_start();
    logic [19:0] prev;
    int done_cnt;
    convert(14'd876);
    prev = model(14'd876);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 14'd1234;
    exp_q.push_back(model(14'd1234));
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus_if.start = (i == 4);
      bus_if.a     = (i == 4) ? 14'd5555 : 14'd0;
      checks++;
      if (bus_if.bcd !== prev) begin
        errors++;
        $display("[TB] FAIL hold_bcd E+%0d: got %05h, required %05h", i, bus_if.bcd, prev);
      end
    end
    bus_if.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_if.done) done_cnt++;
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL ignore_start: got %0d done pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 14'd4321;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.neg, bus_if.bcd} !== 23'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy=%0b done=%0b neg=%0b bcd=%05h, required all 0",
               bus_if.busy, bus_if.done, bus_if.neg, bus_if.bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    convert(14'd42);
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 14'd7;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(14'd7));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.done) done_cnt++;
    end
    bus_if.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.done) done_cnt++;
    end
    checks++;
    if (done_cnt != 3) begin
      errors++;
      $display("[TB] FAIL back_to_back: got %0d done pulses, required 3", done_cnt);
    end
  endtask

  // Test sequence
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d pending results, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
